// File: rtl/matrix_input_loader_pkg.sv
// Shared constants for the matrix pipeline: dimensions, element width, packed layout, FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package matrix_input_loader_pkg;

  localparam int MAX_DIM = 5;
  localparam int ELEM_W  = 8;
  localparam int DIM_W   = 3;
  localparam int SLOT_W  = MAX_DIM * MAX_DIM * ELEM_W;  // 200 bits per matrix
  localparam int PACK_W  = 2 * SLOT_W;                 // two matrices side by side

  // Loader FSM encoding, kept as plain constants so older stages can reuse it
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/matrix_input_loader_if.sv
// Control, element stream and packed-matrix bundle between a producer and the matrix loader.
// Latency: n/a (wiring only).
// Backpressure: elem_valid/elem_ready handshake on the element stream.
interface matrix_input_loader_if;
  import matrix_input_loader_pkg::*;

  logic              start;
  logic [DIM_W-1:0]  m;
  logic [DIM_W-1:0]  n;
  logic              slot;
  logic              elem_valid;
  logic [ELEM_W-1:0] elem_data;
  logic              elem_ready;
  logic [PACK_W-1:0] matrices_out;
  logic              busy;
  logic              done;
  logic              dim_error;

  modport master (
    output start, m, n, slot, elem_valid, elem_data,
    input  elem_ready, matrices_out, busy, done, dim_error
  );

  modport slave (
    input  start, m, n, slot, elem_valid, elem_data,
    output elem_ready, matrices_out, busy, done, dim_error
  );

endinterface

// File: rtl/matrix_input_loader.sv
// Loads an m x n matrix, row-major, into one of two packed 5x5 slots; flags bad dimensions.
// Latency: m*n+2 cycles from accepted start to done pulse; each element visible the cycle after transfer.
// Backpressure: elem_ready high only while loading; elem_valid low simply stalls the load.
module matrix_input_loader #(
  parameter int MAX_DIM = matrix_input_loader_pkg::MAX_DIM,
  parameter int ELEM_W  = matrix_input_loader_pkg::ELEM_W
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_input_loader_if.slave  bus
);
  import matrix_input_loader_pkg::*;

  localparam int L_SLOT_W = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int L_PACK_W = 2 * L_SLOT_W;
  localparam int OFF_W    = $clog2(L_PACK_W);

  logic [1:0]          r_state;
  logic [DIM_W-1:0]    r_row;
  logic [DIM_W-1:0]    r_col;
  logic [DIM_W-1:0]    r_m;
  logic [DIM_W-1:0]    r_n;
  logic                r_slot;
  logic [L_PACK_W-1:0] r_mat;
  logic                r_dim_err;

  logic                w_dims_ok;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_xfer;
  logic                w_last_col;
  logic                w_last_row;
  logic [OFF_W-1:0]    w_bit_off;

  // Decode start acceptance, transfer qualification and the write position
  always_comb begin
    w_dims_ok   = (bus.m != '0) && (int'(bus.m) <= MAX_DIM) &&
                  (bus.n != '0) && (int'(bus.n) <= MAX_DIM);
    w_start_ok  = (r_state == ST_IDLE) && bus.start && w_dims_ok;
    w_start_bad = (r_state == ST_IDLE) && bus.start && !w_dims_ok;
    w_xfer      = (r_state == ST_LOAD) && bus.elem_valid;
    w_last_col  = (r_col == r_n - 3'd1);
    w_last_row  = (r_row == r_m - 3'd1);
    w_bit_off   = OFF_W'((int'(r_row) * MAX_DIM + int'(r_col)) * ELEM_W +
                         (r_slot ? L_SLOT_W : 0));
  end

  // FSM, row-major position counters, latched dimensions and the error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_row     <= '0;
      r_col     <= '0;
      r_m       <= '0;
      r_n       <= '0;
      r_slot    <= 1'b0;
      r_dim_err <= 1'b0;
    end else begin
      r_dim_err <= w_start_bad;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_m     <= bus.m;
            r_n     <= bus.n;
            r_slot  <= bus.slot;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) r_state <= ST_DONE;
              else            r_row   <= r_row + 3'd1;
            end else begin
              r_col <= r_col + 3'd1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Matrix storage: clear the target slot on accepted start, then write one element per transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mat <= '0;
    end else if (w_start_ok) begin
      if (bus.slot) r_mat[L_PACK_W-1:L_SLOT_W] <= '0;
      else          r_mat[L_SLOT_W-1:0]        <= '0;
    end else if (w_xfer) begin
      r_mat[w_bit_off +: ELEM_W] <= bus.elem_data;
    end
  end

  assign bus.elem_ready   = (r_state == ST_LOAD);
  assign bus.busy         = (r_state == ST_LOAD) || (r_state == ST_DONE);
  assign bus.done         = (r_state == ST_DONE);
  assign bus.dim_error    = r_dim_err;
  assign bus.matrices_out = r_mat;

endmodule

// File: tb/tb_matrix_input_loader.sv
// Directed bench for matrix_input_loader: reset, loads, dimension errors, stalls, ignored start, mid-load reset.
// Latency: n/a.
// Backpressure: drives elem_valid continuously or every other cycle.
module tb_matrix_input_loader;
  import matrix_input_loader_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matrix_input_loader_if bus();

  matrix_input_loader #(.MAX_DIM(5), .ELEM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [7:0]   vals [25];
  logic [399:0] exp_mat;
  int           cyc, xfers, last_x;
  bit           seen_done;

  task automatic chkw(input string tag, input logic [399:0] obs, input logic [399:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs == expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a load and stream vals[] until done (bounded). cyc counts from 1 = start cycle.
  task automatic do_load(input logic [2:0] mm, input logic [2:0] nn, input logic sl,
                         input bit toggle, input bit inject,
                         output int o_cyc, output int o_xfers, output int o_last_x,
                         output bit o_done);
    int idx;
    bit x;
    idx = 0; o_cyc = 1; o_xfers = 0; o_last_x = 0; o_done = 1'b0;
    bus.start = 1'b1; bus.m = mm; bus.n = nn; bus.slot = sl;
    bus.elem_data = vals[0]; bus.elem_valid = 1'b1;
    while (!o_done && o_cyc < 100) begin
      x = bus.elem_valid && bus.elem_ready;
      tick;
      if (x) begin
        o_xfers++;
        o_last_x = o_cyc;
        idx++;
      end
      o_cyc++;
      if (inject && o_cyc == 3) begin
        bus.start = 1'b1; bus.m = 3'd1; bus.n = 3'd1;
      end else begin
        bus.start = 1'b0;
      end
      bus.elem_data = (idx < 25) ? vals[idx] : 8'h00;
      if (toggle) bus.elem_valid = !bus.elem_valid;
      o_done = bus.done;
    end
    bus.start = 1'b0;
    bus.elem_valid = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.m = '0; bus.n = '0; bus.slot = 1'b0;
    bus.elem_valid = 1'b0; bus.elem_data = '0;
    reset = 1'b1;
    tick; tick;
    chkw("rst_matrices", bus.matrices_out, '0);
    chk1("rst_ready", bus.elem_ready, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_dimerr", bus.dim_error, 1'b0);
    reset = 1'b0;
    tick;
    chk1("idle_ready", bus.elem_ready, 1'b0);

    // 2x3 into slot 0, continuous stream 1..6
    for (int k = 0; k < 25; k++) vals[k] = 8'(k + 1);
    do_load(3'd2, 3'd3, 1'b0, 1'b0, 1'b0, cyc, xfers, last_x, seen_done);
    chk1("l23_done_seen", seen_done, 1'b1);
    chki("l23_done_cycle", cyc, 8);
    chki("l23_xfers", xfers, 6);
    chk1("l23_busy_in_done", bus.busy, 1'b1);
    chk1("l23_ready_in_done", bus.elem_ready, 1'b0);
    exp_mat = {336'h0, 64'h0605040000030201};
    chkw("l23_matrix", bus.matrices_out, exp_mat);
    tick;
    chk1("l23_done_pulse", bus.done, 1'b0);
    chk1("l23_busy_after", bus.busy, 1'b0);
    tick; tick; tick;
    chkw("l23_hold", bus.matrices_out, exp_mat);

    // Rejected dimensions: m=0 then m=6
    bus.start = 1'b1; bus.m = 3'd0; bus.n = 3'd3; bus.slot = 1'b0;
    tick;
    bus.start = 1'b0;
    chk1("dim0_err", bus.dim_error, 1'b1);
    chk1("dim0_busy", bus.busy, 1'b0);
    tick;
    chk1("dim0_err_pulse", bus.dim_error, 1'b0);
    bus.start = 1'b1; bus.m = 3'd6; bus.n = 3'd2; bus.slot = 1'b1;
    tick;
    bus.start = 1'b0;
    chk1("dim6_err", bus.dim_error, 1'b1);
    chk1("dim6_busy", bus.busy, 1'b0);
    tick;
    chk1("dim6_err_pulse", bus.dim_error, 1'b0);
    chk1("dim6_busy_after", bus.busy, 1'b0);
    chkw("dim_matrix_kept", bus.matrices_out, exp_mat);

    // Full 5x5 into slot 0, then 1x1 0xFF into slot 1
    do_load(3'd5, 3'd5, 1'b0, 1'b0, 1'b0, cyc, xfers, last_x, seen_done);
    chk1("l55_done_seen", seen_done, 1'b1);
    chki("l55_done_cycle", cyc, 27);
    exp_mat = '0;
    for (int k = 0; k < 25; k++) exp_mat[k*8 +: 8] = 8'(k + 1);
    chkw("l55_matrix", bus.matrices_out, exp_mat);
    tick;
    vals[0] = 8'hFF;
    do_load(3'd1, 3'd1, 1'b1, 1'b0, 1'b0, cyc, xfers, last_x, seen_done);
    chki("l11_done_cycle", cyc, 3);
    exp_mat[207:200] = 8'hFF;
    chkw("l11_matrix", bus.matrices_out, exp_mat);
    tick;

    // 3x3 into slot 1 with elem_valid toggling
    for (int k = 0; k < 9; k++) vals[k] = 8'(8'hA1 + k);
    do_load(3'd3, 3'd3, 1'b1, 1'b1, 1'b0, cyc, xfers, last_x, seen_done);
    chk1("l33_done_seen", seen_done, 1'b1);
    chki("l33_xfers", xfers, 9);
    chki("l33_done_after_last", cyc, last_x + 1);
    exp_mat[399:200] = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        exp_mat[200 + (i*5 + j)*8 +: 8] = 8'(8'hA1 + i*3 + j);
    chkw("l33_matrix", bus.matrices_out, exp_mat);
    tick;

    // 2x2 into slot 0 with a 1x1 start pulsed mid-load
    vals[0] = 8'hB1; vals[1] = 8'hB2; vals[2] = 8'hB3; vals[3] = 8'hB4;
    do_load(3'd2, 3'd2, 1'b0, 1'b0, 1'b1, cyc, xfers, last_x, seen_done);
    chk1("inj_done_seen", seen_done, 1'b1);
    chki("inj_xfers", xfers, 4);
    chki("inj_done_cycle", cyc, 6);
    exp_mat[199:0] = '0;
    exp_mat[7:0] = 8'hB1; exp_mat[15:8] = 8'hB2;
    exp_mat[47:40] = 8'hB3; exp_mat[55:48] = 8'hB4;
    chkw("inj_matrix", bus.matrices_out, exp_mat);
    tick;
    chk1("inj_no_dimerr", bus.dim_error, 1'b0);

    // Reset after 4 of 9 elements
    bus.start = 1'b1; bus.m = 3'd3; bus.n = 3'd3; bus.slot = 1'b0;
    tick;
    bus.start = 1'b0;
    bus.elem_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.elem_data = 8'(8'hC1 + k);
      tick;
    end
    chk1("mid_busy", bus.busy, 1'b1);
    reset = 1'b1;
    tick;
    chkw("mid_rst_matrices", bus.matrices_out, '0);
    chk1("mid_rst_ready", bus.elem_ready, 1'b0);
    chk1("mid_rst_busy", bus.busy, 1'b0);
    chk1("mid_rst_done", bus.done, 1'b0);
    chk1("mid_rst_dimerr", bus.dim_error, 1'b0);
    reset = 1'b0;
    bus.elem_valid = 1'b0;
    tick;
    chk1("post_rst_busy", bus.busy, 1'b0);
    chkw("post_rst_matrices", bus.matrices_out, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_input_loader.md
MATRIX_INPUT_LOADER -- requirements
Module: matrix_input_loader

Interface
REQ-001 Parameter MAX_DIM, default 5, meaning largest legal row/column count.
REQ-002 Parameter ELEM_W, default 8, meaning element width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin loading a matrix.
REQ-006 m  input  3  row count, sampled on accepted start.
REQ-007 n  input  3  column count, sampled on accepted start.
REQ-008 slot  input  1  target matrix: 0 = bits [199:0], 1 = bits [399:200]; sampled on accepted start.
REQ-009 elem_valid  input  1  upstream element present.
REQ-010 elem_data  input  8  element value, unsigned.
REQ-011 elem_ready  output  1  loader accepts an element this cycle.
REQ-012 matrices_out  output  400  two packed 5x5 matrices; element (i,j) of slot s at bit offset 200*s + (i*5+j)*8, width 8.
REQ-013 busy  output  1  high in LOAD and DONE.
REQ-014 done  output  1  one-cycle pulse on load completion.
REQ-015 dim_error  output  1  one-cycle pulse on rejected dimensions.

Function
REQ-016 FSM states IDLE, LOAD, DONE; registered state, row counter (3 bits), column counter (3 bits), latched m, n, slot.
REQ-017 IDLE: on start with 1<=m<=5 and 1<=n<=5: latch m, n, slot; zero all 200 bits of target slot; row=col=0; next state LOAD.
REQ-018 IDLE: on start with m or n equal 0 or greater than 5: dim_error=1 next cycle for one cycle; remain IDLE; matrices_out unchanged.
REQ-019 elem_ready = 1 only in LOAD; 0 in IDLE and DONE.
REQ-020 Transfer occurs when elem_valid and elem_ready are both 1; elem_valid low stalls without state change.
REQ-021 On transfer, elem_data written to position (row,col) of latched slot, visible on matrices_out the following cycle.
REQ-022 Counters advance row-major: col+1; when col = n-1, col=0 and row+1.
REQ-023 Transfer at row = m-1 and col = n-1 moves FSM to DONE; no further elements accepted.
REQ-024 DONE lasts exactly one cycle with done=1, then IDLE; done asserted one cycle after last transfer.
REQ-025 Positions with i>=m or j>=n of target slot read 0 after load.
REQ-026 Non-target slot is never modified by a load.
REQ-027 start while in LOAD or DONE is ignored; no relatch, no error.
REQ-028 Matrix contents held unchanged in IDLE until next accepted start for the same slot.
REQ-029 Minimum load of m*n elements takes m*n+2 cycles from start to done (start cycle, m*n transfers, DONE).

Reset
REQ-030 reset overrides all inputs in the same edge: state=IDLE, counters=0, matrices_out=0, elem_ready=0, busy=0, done=0, dim_error=0.
REQ-031 reset during LOAD discards partial matrix; both slots read 0 after reset.

Structure
REQ-032 Shared package holds MAX_DIM, ELEM_W, slot width (200), packed width (400), and FSM state encoding, shared with the scalar-multiply and other matrix stages.
REQ-033 Single module, no sub-module; position index computed as (row*MAX_DIM+col)*ELEM_W plus slot offset.

Verification
REQ-034 reset, start m=2 n=3 slot=0, stream 1..6 continuously -> done at cycle 8 after start; bytes at offsets 0,1,2,5,6,7 = 1..6; all others 0.
REQ-035 start m=0 n=3, then m=6 n=2 -> dim_error pulses twice; busy stays 0; matrices_out unchanged.
REQ-036 Load slot 0 with 5x5 values 0x01..0x19, then slot 1 with m=1 n=1 value 0xFF -> slot 0 intact, bit [207:200]=0xFF, rest of slot 1 zero.
REQ-037 m=3 n=3 with elem_valid toggling every other cycle -> exactly 9 transfers, order preserved, done one cycle after 9th.
REQ-038 start pulsed during LOAD with m=1 n=1 -> ignored; load completes with original dims.
REQ-039 reset asserted after 4 of 9 elements -> next cycle all outputs 0, state IDLE, elem_ready 0.
